// File: rtl/spi_master_pkg.sv
// spi_master_pkg: shared count/watermark types and legacy default watermarks for the SPI master FIFOs.
package spi_master_pkg;
    localparam int CNT_W = 4;
    typedef logic [CNT_W-1:0] cnt_t;
    typedef struct packed {
        cnt_t thr_hi;
        cnt_t thr_lo;
    } wm_cfg_t;
    // 5/4 reproduces the old fixed 4/5-element event behaviour
    localparam cnt_t DEF_THR_HI = cnt_t'(5);
    localparam cnt_t DEF_THR_LO = cnt_t'(4);
endpackage

// File: rtl/spi_master_fifo_wm_evt.sv
// spi_master_fifo_wm_evt: registered single-cycle pulses on high/low watermark crossings.
module spi_master_fifo_wm_evt
    import spi_master_pkg::*;
#(
    parameter int CNT_W_P = CNT_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic [CNT_W_P-1:0] cnt_q_i,
    input  logic [CNT_W_P-1:0] cnt_d_i,
    input  logic [CNT_W_P-1:0] thr_hi_i,
    input  logic [CNT_W_P-1:0] thr_lo_i,
    output logic             evt_hi_o,
    output logic             evt_lo_o
);
    logic hi_q, hi_d, lo_q, lo_d;
    always_comb begin
        hi_d = thr_hi_i != '0 && cnt_q_i < thr_hi_i && cnt_d_i >= thr_hi_i && !clr_i;
        lo_d = thr_lo_i != '0 && cnt_q_i > thr_lo_i && cnt_d_i <= thr_lo_i && !clr_i;
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hi_q <= 1'b0;
            lo_q <= 1'b0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end
    assign evt_hi_o = hi_q;
    assign evt_lo_o = lo_q;
endmodule

// File: rtl/spi_master_fifo_wm.sv
// spi_master_fifo_wm: first-word-fall-through FIFO with watermark events, full/empty and sticky error flags.
module spi_master_fifo_wm
    import spi_master_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int BUFFER_DEPTH = 8,
    localparam int LOG_BUFFER_DEPTH = $clog2(BUFFER_DEPTH)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      clr_i,
    input  logic [DATA_WIDTH-1:0]     data_i,
    input  logic                      valid_i,
    output logic                      ready_o,
    output logic [DATA_WIDTH-1:0]     data_o,
    output logic                      valid_o,
    input  logic                      ready_i,
    output logic [LOG_BUFFER_DEPTH:0] elements_o,
    input  logic [LOG_BUFFER_DEPTH:0] thr_hi_i,
    input  logic [LOG_BUFFER_DEPTH:0] thr_lo_i,
    output logic                      evt_hi_o,
    output logic                      evt_lo_o,
    output logic                      full_o,
    output logic                      empty_o,
    output logic                      ovf_o,
    output logic                      udf_o,
    input  logic                      err_clr_i
);
    localparam int CW = LOG_BUFFER_DEPTH + 1;
    localparam int PW = LOG_BUFFER_DEPTH;
    logic [DATA_WIDTH-1:0] mem_q [BUFFER_DEPTH];
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic ovf_q, ovf_d, udf_q, udf_d, push, pop;
    assign full_o     = cnt_q == CW'(BUFFER_DEPTH);
    assign empty_o    = cnt_q == '0;
    assign ready_o    = !full_o;
    assign valid_o    = !empty_o;
    assign data_o     = mem_q[rd_q];
    assign elements_o = cnt_q;
    assign ovf_o      = ovf_q;
    assign udf_o      = udf_q;
    // explicit wrap so non-power-of-two depths work
    always_comb begin
        push  = valid_i && !full_o;
        pop   = ready_i && !empty_o;
        wr_d  = clr_i ? '0 : !push ? wr_q : wr_q == PW'(BUFFER_DEPTH - 1) ? '0 : wr_q + 1'b1;
        rd_d  = clr_i ? '0 : !pop ? rd_q : rd_q == PW'(BUFFER_DEPTH - 1) ? '0 : rd_q + 1'b1;
        cnt_d = clr_i ? '0 : cnt_q + CW'(push) - CW'(pop);
        ovf_d = (valid_i && full_o) || (ovf_q && !err_clr_i);
        udf_d = (ready_i && empty_o) || (udf_q && !err_clr_i);
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_q] <= data_i;
    end
    spi_master_fifo_wm_evt #(.CNT_W_P(CW)) u_evt (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clr_i    (clr_i),
        .cnt_q_i  (cnt_q),
        .cnt_d_i  (cnt_d),
        .thr_hi_i (thr_hi_i),
        .thr_lo_i (thr_lo_i),
        .evt_hi_o (evt_hi_o),
        .evt_lo_o (evt_lo_o)
    );
endmodule
